// File: rtl/lsu_mem_stage.sv
// Memory stage: captures EX results, runs one data-memory access, emits writeback.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of issuing them.
module lsu_mem_stage (
  input  logic        clk,
  input  logic        rstN,
  input  logic        exValid,
  input  logic [31:0] exAluOut,
  input  logic [31:0] exStoreData,
  input  logic [1:0]  exMemOp,
  input  logic [2:0]  exFunct3,
  input  logic [4:0]  exRd,
  input  logic        exRegWrite,
  output logic        stall,
  output logic [31:0] aluOutMem,
  output logic        dReq,
  output logic        dWe,
  output logic [31:0] dAddr,
  output logic [3:0]  dBe,
  output logic [31:0] dWdata,
  input  logic        dAck,
  input  logic [31:0] dRdata,
  output logic        wbValid,
  output logic [31:0] wbData,
  output logic [4:0]  wbRd,
  output logic        wbRegWrite,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic [2:0]  f3_q, f3_d;
  logic        ld_q, ld_d;
  logic        dreq_q, dreq_d;
  logic        dwe_q, dwe_d;
  logic [3:0]  dbe_q, dbe_d;
  logic [31:0] daddr_q, daddr_d;
  logic [31:0] dwd_q, dwd_d;
  logic        wbv_q, wbv_d;
  logic [31:0] wbd_q, wbd_d;
  logic [4:0]  wbrd_q, wbrd_d;
  logic        wbrw_q, wbrw_d;
  logic        mis_q, mis_d;

  logic        is_ld, is_st, sz_b, sz_h, mis_c;
  logic [3:0]  st_be;
  logic [31:0] st_wd;
  logic        l_b, l_h;
  logic [31:0] sh_w, ld_data;
  logic [15:0] half;

  always_comb begin
    is_ld = exMemOp == 2'b01;
    is_st = exMemOp == 2'b10;
    sz_b  = exFunct3 == 3'b000 ||
            (is_ld && exFunct3 == 3'b100);
    sz_h  = exFunct3 == 3'b001 ||
            (is_ld && exFunct3 == 3'b101);
`ifdef LSU_MISALIGN_TRAP_EN
    mis_c = (is_ld || is_st) &&
            ((sz_h && exAluOut[0]) ||
             (!sz_b && !sz_h && exAluOut[1:0] != 2'b00));
`else
    mis_c = 1'b0;
`endif
    st_be = 4'hF;
    st_wd = exStoreData;
    if (sz_b) begin
      st_be = 4'b0001 << exAluOut[1:0];
      st_wd = {4{exStoreData[7:0]}};
    end else if (sz_h) begin
      st_be = exAluOut[1] ? 4'b1100 : 4'b0011;
      st_wd = {2{exStoreData[15:0]}};
    end
  end

  // Lane extraction uses the latched address and size of the pending load
  always_comb begin
    l_b  = f3_q == 3'b000 || f3_q == 3'b100;
    l_h  = f3_q == 3'b001 || f3_q == 3'b101;
    sh_w = dRdata >> {alu_q[1:0], 3'b000};
    half = alu_q[1] ? dRdata[31:16] : dRdata[15:0];
    if (l_b)
      ld_data = {{24{~f3_q[2] & sh_w[7]}}, sh_w[7:0]};
    else if (l_h)
      ld_data = {{16{~f3_q[2] & half[15]}}, half};
    else
      ld_data = dRdata;
  end

  always_comb begin
    state_d = state_q;
    alu_d   = alu_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    f3_d    = f3_q;
    ld_d    = ld_q;
    dreq_d  = dreq_q;
    dwe_d   = dwe_q;
    dbe_d   = dbe_q;
    daddr_d = daddr_q;
    dwd_d   = dwd_q;
    wbv_d   = 1'b0;
    wbd_d   = wbd_q;
    wbrd_d  = wbrd_q;
    wbrw_d  = 1'b0;
    mis_d   = 1'b0;
    unique case (state_q)
      IDLE: if (exValid) begin
        alu_d = exAluOut;
        rd_d  = exRd;
        rw_d  = exRegWrite;
        f3_d  = exFunct3;
        ld_d  = is_ld;
        if ((is_ld || is_st) && !mis_c) begin
          state_d = REQ;
          dreq_d  = 1'b1;
          dwe_d   = is_st;
          dbe_d   = st_be;
          daddr_d = {exAluOut[31:2], 2'b00};
          dwd_d   = st_wd;
        end else begin
          wbv_d  = 1'b1;
          wbd_d  = exAluOut;
          wbrd_d = exRd;
          wbrw_d = !mis_c && exRegWrite &&
                   exRd != 5'd0;
          mis_d  = mis_c;
        end
      end
      REQ: if (dAck) begin
        state_d = RESP;
        dreq_d  = 1'b0;
        dwe_d   = 1'b0;
        wbv_d   = 1'b1;
        wbd_d   = ld_q ? ld_data : alu_q;
        wbrd_d  = rd_q;
        wbrw_d  = ld_q && rw_q && rd_q != 5'd0;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= IDLE;
      alu_q   <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      f3_q    <= '0;
      ld_q    <= 1'b0;
      dreq_q  <= 1'b0;
      dwe_q   <= 1'b0;
      dbe_q   <= '0;
      daddr_q <= '0;
      dwd_q   <= '0;
      wbv_q   <= 1'b0;
      wbd_q   <= '0;
      wbrd_q  <= '0;
      wbrw_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      f3_q    <= f3_d;
      ld_q    <= ld_d;
      dreq_q  <= dreq_d;
      dwe_q   <= dwe_d;
      dbe_q   <= dbe_d;
      daddr_q <= daddr_d;
      dwd_q   <= dwd_d;
      wbv_q   <= wbv_d;
      wbd_q   <= wbd_d;
      wbrd_q  <= wbrd_d;
      wbrw_q  <= wbrw_d;
      mis_q   <= mis_d;
    end
  end

  assign stall      = rstN && state_q != IDLE;
  assign aluOutMem  = alu_q;
  assign dReq       = dreq_q;
  assign dWe        = dwe_q;
  assign dAddr      = daddr_q;
  assign dBe        = dbe_q;
  assign dWdata     = dwd_q;
  assign wbValid    = wbv_q;
  assign wbData     = wbd_q;
  assign wbRd       = wbrd_q;
  assign wbRegWrite = wbrw_q;
  assign misalign   = mis_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed testbench for lsu_mem_stage.
// Vector table for ALU/memory ops plus hand sequences for reset and misalign.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rstN;
  logic        exValid;
  logic [31:0] exAluOut, exStoreData;
  logic [1:0]  exMemOp;
  logic [2:0]  exFunct3;
  logic [4:0]  exRd;
  logic        exRegWrite;
  logic        stall;
  logic [31:0] aluOutMem;
  logic        dReq, dWe;
  logic [31:0] dAddr;
  logic [3:0]  dBe;
  logic [31:0] dWdata;
  logic        dAck;
  logic [31:0] dRdata;
  logic        wbValid;
  logic [31:0] wbData;
  logic [4:0]  wbRd;
  logic        wbRegWrite;
  logic        misalign;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_mem_stage dut (
    .clk(clk), .rstN(rstN), .exValid(exValid),
    .exAluOut(exAluOut), .exStoreData(exStoreData),
    .exMemOp(exMemOp), .exFunct3(exFunct3),
    .exRd(exRd), .exRegWrite(exRegWrite),
    .stall(stall), .aluOutMem(aluOutMem),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr),
    .dBe(dBe), .dWdata(dWdata), .dAck(dAck),
    .dRdata(dRdata), .wbValid(wbValid),
    .wbData(wbData), .wbRd(wbRd),
    .wbRegWrite(wbRegWrite), .misalign(misalign)
  );

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] rdata;
    int          dly;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] wb;
    logic        wrw;
  } vec_t;

  vec_t v[13];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(logic [1:0] op, logic [2:0] f3,
                       logic [31:0] a, logic [31:0] sd,
                       logic [4:0] rd, logic rw);
    exValid     = 1'b1;
    exMemOp     = op;
    exFunct3    = f3;
    exAluOut    = a;
    exStoreData = sd;
    exRd        = rd;
    exRegWrite  = rw;
  endtask

  task automatic run_vec(int i, vec_t t);
    string p;
    p = $sformatf("v%0d", i);
    drive(t.op, t.f3, t.addr, t.sdata, t.rd, t.rw);
    tick();
    exValid = 1'b0;
    chk({p, "_alumem"}, aluOutMem, t.addr);
    if (t.op == 2'b00) begin
      chk({p, "_wbv"}, wbValid, 1);
      chk({p, "_wbd"}, wbData, t.wb);
      chk({p, "_wbrd"}, wbRd, t.rd);
      chk({p, "_wbrw"}, wbRegWrite, t.wrw);
      chk({p, "_stall"}, stall, 0);
      chk({p, "_dreq"}, dReq, 0);
    end else begin
      chk({p, "_dreq"}, dReq, 1);
      chk({p, "_stall"}, stall, 1);
      chk({p, "_daddr"}, dAddr,
          {t.addr[31:2], 2'b00});
      chk({p, "_dbe"}, dBe, t.be);
      chk({p, "_dwd"}, dWdata, t.wd);
      chk({p, "_dwe"}, dWe, t.op == 2'b10);
      chk({p, "_wbv0"}, wbValid, 0);
      for (int k = 0; k < t.dly; k++) begin
        tick();
        chk({p, "_hreq"}, dReq, 1);
        chk({p, "_hstall"}, stall, 1);
        chk({p, "_hbe"}, dBe, t.be);
      end
      dAck   = 1'b1;
      dRdata = t.rdata;
      tick();
      dAck   = 1'b0;
      dRdata = 32'h0;
      chk({p, "_rdreq"}, dReq, 0);
      chk({p, "_rstall"}, stall, 1);
      chk({p, "_rwbv"}, wbValid, 1);
      chk({p, "_rwbd"}, wbData, t.wb);
      chk({p, "_rwbrd"}, wbRd, t.rd);
      chk({p, "_rwbrw"}, wbRegWrite, t.wrw);
      tick();
      chk({p, "_istall"}, stall, 0);
      chk({p, "_iwbv"}, wbValid, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // op f3 addr sdata rd rw rdata dly be wd wb wrw
    v[0]  = '{2'b00, 3'b000, 32'h1234, 0, 5, 1,
              0, 0, 0, 0, 32'h1234, 1};
    v[1]  = '{2'b00, 3'b000, 32'hDEADBEEF, 0, 0, 1,
              0, 0, 0, 0, 32'hDEADBEEF, 0};
    v[2]  = '{2'b00, 3'b010, 32'h5, 0, 31, 0,
              0, 0, 0, 0, 32'h5, 0};
    v[3]  = '{2'b01, 3'b000, 32'h103, 0, 7, 1,
              32'h80FFFFFF, 3, 4'b1000, 0,
              32'hFFFFFF80, 1};
    v[4]  = '{2'b10, 3'b001, 32'h102, 32'h0000BEEF,
              9, 1, 0, 0, 4'b1100, 32'hBEEFBEEF,
              32'h102, 0};
    v[5]  = '{2'b01, 3'b101, 32'h200, 0, 3, 1,
              32'h0000F00D, 0, 4'b0011, 0,
              32'h0000F00D, 1};
    v[6]  = '{2'b01, 3'b001, 32'h202, 0, 4, 1,
              32'h80011234, 1, 4'b1100, 0,
              32'hFFFF8001, 1};
    v[7]  = '{2'b01, 3'b100, 32'h101, 0, 6, 1,
              32'h123480AB, 0, 4'b0010, 0,
              32'h00000080, 1};
    v[8]  = '{2'b01, 3'b010, 32'h300, 0, 8, 1,
              32'hCAFEF00D, 2, 4'b1111, 0,
              32'hCAFEF00D, 1};
    v[9]  = '{2'b10, 3'b000, 32'h201, 32'h123456A5,
              10, 0, 0, 0, 4'b0010, 32'hA5A5A5A5,
              32'h201, 0};
    v[10] = '{2'b10, 3'b010, 32'h404, 32'h11223344,
              11, 1, 0, 1, 4'b1111, 32'h11223344,
              32'h404, 0};
    v[11] = '{2'b01, 3'b011, 32'h10, 0, 12, 1,
              32'h89ABCDEF, 0, 4'b1111, 0,
              32'h89ABCDEF, 1};
    v[12] = '{2'b01, 3'b000, 32'h100, 0, 0, 1,
              32'h0000007F, 0, 4'b0001, 0,
              32'h0000007F, 0};

    rstN = 1'b0; exValid = 1'b0; exAluOut = '0;
    exStoreData = '0; exMemOp = '0; exFunct3 = '0;
    exRd = '0; exRegWrite = 1'b0;
    dAck = 1'b0; dRdata = '0;
    tick();
    tick();
    chk("rst_stall", stall, 0);
    chk("rst_dreq", dReq, 0);
    chk("rst_wbv", wbValid, 0);
    chk("rst_alu", aluOutMem, 0);
    chk("rst_dbe", dBe, 0);
    chk("rst_mis", misalign, 0);
    chk("rst_wbrw", wbRegWrite, 0);
    rstN = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) run_vec(i, v[i]);

    // back-to-back ALU ops
    drive(2'b00, 3'b000, 32'hA1, 0, 1, 1);
    tick();
    chk("b2b0_wbd", wbData, 32'hA1);
    chk("b2b0_wbv", wbValid, 1);
    drive(2'b00, 3'b000, 32'hB2, 0, 2, 1);
    tick();
    exValid = 1'b0;
    chk("b2b1_wbd", wbData, 32'hB2);
    chk("b2b1_wbrd", wbRd, 2);
    chk("b2b1_wbv", wbValid, 1);
    tick();
    chk("b2b_idle_wbv", wbValid, 0);

    // dAck while idle is ignored
    dAck = 1'b1; dRdata = 32'h55;
    tick();
    dAck = 1'b0;
    chk("ack_idle_wbv", wbValid, 0);
    chk("ack_idle_stall", stall, 0);

    // stalled capture attempt, then reset mid-REQ
    drive(2'b01, 3'b010, 32'h500, 0, 13, 1);
    tick();
    drive(2'b00, 3'b000, 32'hFFFF, 0, 14, 1);
    tick();
    chk("stl_alu_hold", aluOutMem, 32'h500);
    chk("stl_dreq", dReq, 1);
    chk("stl_wbv", wbValid, 0);
    exValid = 1'b0;
    rstN = 1'b0;
    #1;
    chk("rstlow_stall", stall, 0);
    tick();
    rstN = 1'b1;
    chk("mrst_dreq", dReq, 0);
    chk("mrst_wbv", wbValid, 0);
    chk("mrst_alu", aluOutMem, 0);
    chk("mrst_daddr", dAddr, 0);
    dAck = 1'b1; dRdata = 32'h77;
    tick();
    dAck = 1'b0;
    chk("mrst_ack_wbv", wbValid, 0);
    chk("mrst_ack_stall", stall, 0);
    tick();
    chk("mrst_ack_wbv2", wbValid, 0);

    // misaligned LW at 0x101
    drive(2'b01, 3'b010, 32'h101, 0, 15, 1);
    tick();
    exValid = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_dreq", dReq, 0);
    chk("mis_pulse", misalign, 1);
    chk("mis_wbv", wbValid, 1);
    chk("mis_wbrw", wbRegWrite, 0);
    chk("mis_stall", stall, 0);
    tick();
    chk("mis_pulse_end", misalign, 0);
    chk("mis_dreq2", dReq, 0);
`else
    chk("mis_dreq", dReq, 1);
    chk("mis_pulse", misalign, 0);
    chk("mis_daddr", dAddr, 32'h100);
    chk("mis_dbe", dBe, 4'hF);
    dAck = 1'b1; dRdata = 32'h01020304;
    tick();
    dAck = 1'b0;
    chk("mis_wbd", wbData, 32'h01020304);
    chk("mis_wbrw", wbRegWrite, 1);
    chk("mis_pulse2", misalign, 0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
